// File: rtl/lcm_gcd_div.sv
// lcm_gcd_div: recovers gcd = (n1*n2)/lcm from an operand pair and the LCM
// produced upstream, so that the (LCM, GCD) pair can be cross-checked.
// Datapath: W-step shift-add multiplier into a 2W-bit product, followed by
// a 2W-step restoring divider. err flags lcm==0, a quotient that does not
// fit in W bits, or a nonzero remainder.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active low
//   start - request, sampled only while busy=0
//   n1,n2 - operands, captured on the accepting edge
//   lcm   - LCM of n1,n2 from upstream, captured on the accepting edge
//   busy  - high from the accepting edge until the edge that raises done
//   done  - one-cycle pulse, gcd/err valid from this cycle
//   gcd   - result, held until the next done
//   err   - result status, held until the next done
module lcm_gcd_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] n1,
  input  logic [W-1:0] n2,
  input  logic [W-1:0] lcm,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] gcd,
  output logic         err
);

  localparam int CW = $clog2(2 * W);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t state, state_nxt;

  logic [2*W-1:0] mcand;   // n1 shifted left once per MUL step
  logic [W-1:0]   mplier;  // n2 shifted right once per MUL step
  logic [W-1:0]   dvsr;    // captured lcm
  logic [2*W-1:0] p;       // product; doubles as the dividend shifter in DIV
  logic [2*W-1:0] q;       // quotient
  logic [W-1:0]   r;       // partial remainder, always < dvsr after a step
  logic [CW-1:0]  cnt;
  logic           zerr;    // lcm was zero at capture

  logic           mul_last, div_last;
  logic [W:0]     r_sh;
  logic           sub_ok;
  logic [W-1:0]   r_sub;
  logic           err_nxt;

  assign mul_last = (cnt == CW'(W - 1));
  assign div_last = (cnt == CW'(2 * W - 1));

  // One restoring-division step: bring in the next dividend bit MSB first.
  // r < dvsr, so the difference always fits back into W bits.
  assign r_sh   = {r, p[2*W-1]};
  assign sub_ok = (r_sh >= {1'b0, dvsr});
  assign r_sub  = W'(r_sh - {1'b0, dvsr});

  assign err_nxt = zerr | (|q[2*W-1:W]) | (|r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (lcm == '0) ? FIN : MUL;
      MUL:     if (mul_last) state_nxt = DIV;
      DIV:     if (div_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      dvsr   <= '0;
      p      <= '0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      zerr   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      gcd    <= '0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{W{1'b0}}, n1};
            mplier <= n2;
            dvsr   <= lcm;
            zerr   <= (lcm == '0);
            p      <= '0;
            q      <= '0;
            r      <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        MUL: begin
          if (mplier[0]) p <= p + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (mul_last) begin
            // p becomes the dividend in place; remainder/quotient start clean
            cnt <= '0;
            r   <= '0;
            q   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DIV: begin
          p   <= {p[2*W-2:0], 1'b0};
          r   <= sub_ok ? r_sub : r_sh[W-1:0];
          q   <= {q[2*W-2:0], sub_ok};
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          err  <= err_nxt;
          gcd  <= err_nxt ? '0 : q[W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_gcd_div.sv
// Scoreboard bench for lcm_gcd_div: the driver pushes the expected response
// (value, status, acceptance edge, latency) when a request is accepted; an
// independent monitor pops and compares on every done pulse.
module tb_lcm_gcd_div;

  localparam int W = 32;

  logic         clk, rst, start;
  logic [W-1:0] n1, n2, lcm;
  logic         busy, done, err;
  logic [W-1:0] gcd;

  lcm_gcd_div #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .n1(n1), .n2(n2), .lcm(lcm),
    .busy(busy), .done(done), .gcd(gcd), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    logic         e;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the definition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] l);
    exp_t x;
    longint unsigned prod, quo;
    prod  = longint'(a) * longint'(b);
    x.g   = '0;
    x.e   = 1'b0;
    x.acc = 0;
    x.lat = (l == 0) ? 1 : 3 * W + 1;
    if (l == 0) x.e = 1'b1;
    else begin
      quo = prod / longint'(l);
      if ((prod % longint'(l)) != 0 || (quo >> W) != 0) x.e = 1'b1;
      else x.g = quo[W-1:0];
    end
    return x;
  endfunction

  function automatic longint unsigned euclid(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Monitor
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(done), 64'(0));
        end else begin
          me = sb.pop_front();
          chk("gcd", 64'(gcd), 64'(me.g));
          chk("err", 64'(err), 64'(me.e));
          chk("latency", 64'(cyc - me.acc), 64'(me.lat));
          chk("busy_at_done", 64'(busy), 64'(0));
        end
      end else if (sb.size() != 0) begin
        chk("busy_inflight", 64'(busy), 64'(1));
      end
    end
  end

  task automatic wait_idle_neg();
    int t = 0;
    @(negedge clk);
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("accept_timeout", 64'(busy), 64'(0));
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] l, input exp_t x);
    wait_idle_neg();
    start = 1'b1;
    n1 = a; n2 = b; lcm = l;
    x.acc = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    // garbage while busy must not matter
    n1 = $urandom; n2 = $urandom; lcm = $urandom;
  endtask

  task automatic send_dir(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] l, input logic [W-1:0] eg, input logic ee);
    exp_t x;
    x.g = eg; x.e = ee; x.acc = 0;
    x.lat = (l == 0) ? 1 : 3 * W + 1;
    issue(a, b, l, x);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic gen(output logic [W-1:0] a, output logic [W-1:0] b, output logic [W-1:0] l);
    longint unsigned g, x, y, la;
    int mode;
    g = $urandom_range(1, 1000);
    x = $urandom_range(0, 3000);
    y = $urandom_range(0, 3000);
    a = W'(g * x);
    b = W'(g * y);
    mode = $urandom_range(0, 9);
    if (a == 0 || b == 0) la = $urandom_range(1, 100);
    else la = (longint'(a) * longint'(b)) / euclid(longint'(a), longint'(b));
    if (mode < 6)       l = W'(la);
    else if (mode == 6) l = W'(la) + W'($urandom_range(1, 5));
    else if (mode == 7) l = '0;
    else begin
      a = $urandom; b = $urandom; l = $urandom;
    end
  endtask

  initial begin
    logic [W-1:0] a, b, l;
    rst = 1'b0; start = 1'b0; n1 = '0; n2 = '0; lcm = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_gcd",  64'(gcd),  64'(0));
    chk("rst_err",  64'(err),  64'(0));
    rst = 1'b1;

    // directed cases with hand-derived results
    send_dir(32'd12, 32'd18, 32'd36, 32'd6, 1'b0); drain();
    send_dir(32'd7, 32'd5, 32'd35, 32'd1, 1'b0);   drain();
    send_dir(32'd4, 32'd6, 32'd0, 32'd0, 1'b1);    drain();
    send_dir(32'd12, 32'd18, 32'd36, 32'd6, 1'b0); drain();
    send_dir(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); drain();
    send_dir(32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b1); drain();
    send_dir(32'd12, 32'd18, 32'd35, 32'd0, 1'b1); drain();
    send_dir(32'd0, 32'd9, 32'd9, 32'd0, 1'b0);    drain();

    // start held high, operands changing every cycle
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      gen(a, b, l);
      n1 = a; n2 = b; lcm = l;
      if (!busy) begin
        me = model(a, b, l);
        me.acc = cyc + 1;
        sb.push_back(me);
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // randomized back-to-back requests
    for (int i = 0; i < 30; i++) begin
      gen(a, b, l);
      issue(a, b, l, model(a, b, l));
    end
    drain();

    // asynchronous reset during the divide phase
    send_dir(32'd100, 32'd75, 32'd300, 32'd25, 1'b0);
    repeat (W + 10) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_gcd",  64'(gcd),  64'(0));
    chk("arst_err",  64'(err),  64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (120) @(negedge clk);
    send_dir(32'd12, 32'd18, 32'd36, 32'd6, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
